// File: rtl/sha256_message_padder.sv
// Purpose: SHA-256 message padder; packs 32-bit big-endian words into 512-bit blocks with 0x80, zero fill and bit length.
// Latency: a block is valid the cycle after its completing input word; a length-only block follows its predecessor's handshake.
// Backpressure: input ready only while filling; a held block stays stable until o_data_out_ready. Optional macro: SHA256_PADDER_BYTE_EN.
module sha256_message_padder #(
  parameter int LENWIDTH = 64
) (
  input  logic         i_clk,
  input  logic         i_sync_rst,
  input  logic [31:0]  i_data_in,
  input  logic [2:0]   i_data_in_bytes,
  input  logic         i_data_in_last,
  input  logic         i_data_in_valid,
  output logic         o_data_in_ready,
  output logic [511:0] o_data_out,
  output logic         o_data_out_last,
  output logic         o_data_out_valid,
  input  logic         i_data_out_ready
);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    OUT     = 2'd1,
    OUT_LEN = 2'd2
  } state_t;

  state_t              r_state;
  logic [15:0][31:0]   r_buf;       // r_buf[15] is block word 0
  logic [3:0]          r_widx;
  logic [LENWIDTH-1:0] r_bitcnt;
  logic                r_pending;   // a length-only block must follow the current one
  logic                r_pad80;     // the 0x80 byte did not fit in the current block
  logic                r_out_vld;
  logic                r_out_last;

  logic [2:0]          w_nbytes;
  logic [31:0]         w_word;
  logic [6:0]          w_pos;
  logic [LENWIDTH-1:0] w_bitcnt_nxt;
  logic [63:0]         w_len_nxt;
  logic [63:0]         w_len_cur;
  logic [3:0]          w_slot;
  logic [3:0]          w_slot_nxt;
  logic                w_in_fire;

`ifdef SHA256_PADDER_BYTE_EN
  // Values above 4 are treated as a full word.
  assign w_nbytes = (i_data_in_bytes > 3'd4) ? 3'd4 : i_data_in_bytes;
`else
  // Byte count is ignored: every word carries four message bytes.
  logic w_unused_bytes;
  assign w_unused_bytes = ^i_data_in_bytes;
  assign w_nbytes       = 3'd4;
`endif

  assign o_data_in_ready  = (r_state == FILL) && !i_sync_rst;
  assign o_data_out       = r_buf;
  assign o_data_out_valid = r_out_vld;
  assign o_data_out_last  = r_out_last;

  assign w_in_fire    = o_data_in_ready && i_data_in_valid;
  assign w_pos        = {1'b0, r_widx, 2'b00} + {4'b0000, w_nbytes};
  assign w_bitcnt_nxt = r_bitcnt + LENWIDTH'({w_nbytes, 3'b000});
  assign w_slot       = 4'd15 - r_widx;
  assign w_slot_nxt   = 4'd14 - r_widx;

  // Keep the valid bytes of the incoming word, mark the first unused byte with 0x80, zero the rest.
  always_comb begin
    w_word = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < w_nbytes)
        w_word[31-8*b -: 8] = i_data_in[31-8*b -: 8];
      else if (3'(b) == w_nbytes)
        w_word[31-8*b -: 8] = 8'h80;
    end
  end

  // Zero-extend the bit counter (both the updated and the held value) into the 64-bit length field.
  always_comb begin
    w_len_nxt = '0;
    w_len_cur = '0;
    w_len_nxt[LENWIDTH-1:0] = w_bitcnt_nxt;
    w_len_cur[LENWIDTH-1:0] = r_bitcnt;
  end

  // Control FSM: fill the block buffer, emit it, and emit a trailing length block when needed.
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      r_state    <= FILL;
      r_buf      <= '0;
      r_widx     <= '0;
      r_bitcnt   <= '0;
      r_pending  <= 1'b0;
      r_pad80    <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_in_fire) begin
            r_buf[w_slot] <= w_word;
            r_bitcnt      <= w_bitcnt_nxt;
            r_widx        <= r_widx + 4'd1;
            if (i_data_in_last) begin
              // A full last word pushes the 0x80 marker into the next word, if one is left.
              if (w_nbytes == 3'd4 && r_widx != 4'd15)
                r_buf[w_slot_nxt] <= 32'h8000_0000;
              r_state   <= OUT;
              r_out_vld <= 1'b1;
              if (w_pos <= 7'd55) begin
                r_buf[1]   <= w_len_nxt[63:32];
                r_buf[0]   <= w_len_nxt[31:0];
                r_out_last <= 1'b1;
              end else begin
                // No room for the length: this block goes out unterminated.
                r_pending  <= 1'b1;
                r_pad80    <= (w_pos == 7'd64);
                r_out_last <= 1'b0;
              end
            end else if (r_widx == 4'd15) begin
              r_state    <= OUT;
              r_out_vld  <= 1'b1;
              r_out_last <= 1'b0;
            end
          end
        end
        OUT, OUT_LEN: begin
          if (i_data_out_ready) begin
            r_buf  <= '0;
            r_widx <= '0;
            if (r_out_last) begin
              r_bitcnt   <= '0;
              r_state    <= FILL;
              r_out_vld  <= 1'b0;
              r_out_last <= 1'b0;
            end else if (r_pending) begin
              r_buf[15]  <= r_pad80 ? 32'h8000_0000 : 32'h0000_0000;
              r_buf[1]   <= w_len_cur[63:32];
              r_buf[0]   <= w_len_cur[31:0];
              r_pending  <= 1'b0;
              r_pad80    <= 1'b0;
              r_state    <= OUT_LEN;
              r_out_last <= 1'b1;
            end else begin
              // Mid-message block: keep counting bits across the boundary.
              r_state   <= FILL;
              r_out_vld <= 1'b0;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule
